spi_master_tx: RTL and testbench

SPI mode-0 master transmitter that serialises bytes from a valid/ready stream onto SCLK/MOSI with chip select. It is the driving end of the serial link whose receiver counts bits 7 down to 0 on rising SCLK. It sits between the on-chip control logic (system clock domain) and the SPI pads. All outputs are registered except `tx_ready_o` and `busy_o`, which decode state.

---
 rtl/spi_master_tx.sv | 198 +++++++++++++++++++
 tb/tb_spi_master_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: serialises valid/ready bytes MSB first onto SCLK/MOSI with CS.
// Optional MISO capture path is enabled by defining SPI_TX_MISO_EN.
module spi_master_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       busy_o,
    output logic       sclk_o,
    output logic       mosi_o,
`ifdef SPI_TX_MISO_EN
    input  logic       miso_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
`endif
    output logic       cs_n_o
);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("spi_master_tx: CLK_DIV must be >= 1");
    end

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_TRAIL = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            cs_n_q, cs_n_d;
    logic            phase_end_s;
    logic            terminal_s;
    logic            accept_s;

    assign phase_end_s = (div_cnt_q == DIV_LAST);
    assign terminal_s  = (state_q == ST_LOW) && phase_end_s && (bit_cnt_q == 3'd0);
    assign tx_ready_o  = (state_q == ST_IDLE) || terminal_s;
    assign accept_s    = tx_valid_i && tx_ready_o;
    assign busy_o      = (state_q != ST_IDLE);
    assign sclk_o      = sclk_q;
    assign mosi_o      = mosi_q;
    assign cs_n_o      = cs_n_q;

    // Next-state and output-register logic for the transfer sequencer
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        if (state_q == ST_IDLE || phase_end_s) begin
            div_cnt_d = {DW{1'b0}};
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d   = ST_LEAD;
                    shreg_d   = tx_data_i;
                    bit_cnt_d = 3'd7;
                    mosi_d    = tx_data_i[7];
                    cs_n_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LEAD: begin
                if (phase_end_s) begin
                    state_d = ST_HIGH;
                    sclk_d  = 1'b1;
                end else begin
                    state_d = ST_LEAD;
                end
            end
            ST_HIGH: begin
                // MOSI advances on the falling SCLK edge so it has a full phase of setup
                if (phase_end_s) begin
                    state_d = ST_LOW;
                    sclk_d  = 1'b0;
                    if (bit_cnt_q != 3'd0) begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                        mosi_d  = shreg_q[6];
                    end else begin
                        shreg_d = shreg_q;
                    end
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (!phase_end_s) begin
                    state_d = ST_LOW;
                end else if (bit_cnt_q != 3'd0) begin
                    state_d   = ST_HIGH;
                    sclk_d    = 1'b1;
                    bit_cnt_d = bit_cnt_q - 3'd1;
                end else if (accept_s) begin
                    state_d   = ST_HIGH;
                    sclk_d    = 1'b1;
                    shreg_d   = tx_data_i;
                    bit_cnt_d = 3'd7;
                    mosi_d    = tx_data_i[7];
                end else begin
                    state_d = ST_TRAIL;
                end
            end
            ST_TRAIL: begin
                if (phase_end_s) begin
                    state_d = ST_IDLE;
                    cs_n_d  = 1'b1;
                end else begin
                    state_d = ST_TRAIL;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                sclk_d    = 1'b0;
                cs_n_d    = 1'b1;
                bit_cnt_d = 3'd7;
            end
        endcase
    end

    // Sequencer state and registered SPI pins
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= {DW{1'b0}};
            bit_cnt_q <= 3'd7;
            shreg_q   <= 8'h00;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
        end
    end

`ifdef SPI_TX_MISO_EN
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;

    // MISO is captured on the edge that raises SCLK; the byte is published after the terminal cycle
    always_comb begin
        if (state_d == ST_HIGH && state_q != ST_HIGH) begin
            rx_shift_d = {rx_shift_q[6:0], miso_i};
        end else begin
            rx_shift_d = rx_shift_q;
        end
        if (terminal_s) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end else begin
            rx_data_d  = rx_data_q;
            rx_valid_d = 1'b0;
        end
    end

    // Receive path registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed, table-driven bench for spi_master_tx (CLK_DIV = 4; CLK_DIV = 1 loopback when SPI_TX_MISO_EN is defined).
module tb_spi_master_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, sclk, mosi, cs_n;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

`ifdef SPI_TX_MISO_EN
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data1 = 8'h00;
    logic       tx_valid1 = 1'b0;
    logic       tx_ready1, busy1, sclk1, mosi1, cs_n1, rx_valid1;
    logic [7:0] rx_data1;
    int         rx_pulses1 = 0;
`endif

    spi_master_tx #(.CLK_DIV(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready), .busy_o(busy), .sclk_o(sclk), .mosi_o(mosi),
`ifdef SPI_TX_MISO_EN
        .miso_i(mosi), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
`endif
        .cs_n_o(cs_n)
    );

`ifdef SPI_TX_MISO_EN
    spi_master_tx #(.CLK_DIV(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data1), .tx_valid_i(tx_valid1),
        .tx_ready_o(tx_ready1), .busy_o(busy1), .sclk_o(sclk1), .mosi_o(mosi1),
        .miso_i(mosi1), .rx_data_o(rx_data1), .rx_valid_o(rx_valid1),
        .cs_n_o(cs_n1)
    );

    always @(negedge clk) begin
        if (rx_valid1) rx_pulses1 <= rx_pulses1 + 1;
    end
`endif

    // Receiver-side monitor, sampled on the falling clk edge
    logic        mon_clr = 1'b0;
    logic        prev_sclk = 1'b0;
    logic [15:0] rx_bits;
    int          rises, cs_low, first_rise, since_rise, max_gap, accepts, ready_busy;

    always @(negedge clk) begin
        prev_sclk <= sclk;
        if (mon_clr) begin
            rx_bits <= 16'h0000; rises <= 0; cs_low <= 0; first_rise <= -1;
            since_rise <= 0; max_gap <= 0; accepts <= 0; ready_busy <= 0;
        end else begin
            if (!cs_n) cs_low <= cs_low + 1;
            if (tx_valid && tx_ready) accepts <= accepts + 1;
            if (busy && tx_ready) ready_busy <= ready_busy + 1;
            if (sclk && !prev_sclk) begin
                rx_bits    <= {rx_bits[14:0], mosi};
                rises      <= rises + 1;
                since_rise <= 0;
                if (rises == 0) first_rise <= cs_low;
                else if (since_rise + 1 > max_gap) max_gap <= since_rise + 1;
            end else begin
                since_rise <= since_rise + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Offers a byte and holds it until accepted; called just after a rising edge
    task automatic handshake(input logic [7:0] d);
        bit done = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if (tx_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        tx_valid = 1'b0;
        check("handshake_accepted", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_byte;
        int         exp_rises;
        int         exp_cs;
        int         exp_first;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 8, 72, 4};
        vecs[1] = '{8'h00, 8'h00, 8, 72, 4};
        vecs[2] = '{8'hFF, 8'hFF, 8, 72, 4};
        vecs[3] = '{8'h01, 8'h01, 8, 72, 4};
        vecs[4] = '{8'h80, 8'h80, 8, 72, 4};

        // Asynchronous reset in the middle of a clock period
        #12 rst = 1'b1;
        #1 check("reset_outputs", {27'd0, cs_n, sclk, mosi, busy, tx_ready}, {27'd0, 5'b10001});
        @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();

        for (int v = 0; v < 5; v++) begin
            clear_mon();
            handshake(vecs[v].data);
            wait_idle();
            check("single_byte", {24'd0, rx_bits[7:0]}, {24'd0, vecs[v].exp_byte});
            check("single_rises", rises, vecs[v].exp_rises);
            check("single_cs_low", cs_low, vecs[v].exp_cs);
            check("single_first_rise", first_rise, vecs[v].exp_first);
        end

        // Back-to-back: the second byte is offered while the first is still shifting
        clear_mon();
        handshake(8'h3C);
        handshake(8'hC3);
        wait_idle();
        check("b2b_bits", {16'd0, rx_bits}, 32'h0000_3CC3);
        check("b2b_rises", rises, 32'd16);
        check("b2b_cs_low", cs_low, 32'd136);
        check("b2b_sclk_gap", max_gap, 32'd8);
        check("b2b_accepts", accepts, 32'd2);
        // one mid-stream terminal cycle plus the final one
        check("b2b_ready_busy", ready_busy, 32'd2);

        // Backpressure: valid with changing data while mid-byte must be ignored
        clear_mon();
        handshake(8'hA5);
        tx_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tx_data = (i % 2 == 0) ? 8'h00 : 8'hFF;
            @(posedge clk);
            #1;
        end
        tx_valid = 1'b0;
        wait_idle();
        check("bp_byte", {24'd0, rx_bits[7:0]}, 32'h0000_00A5);
        check("bp_accepts", accepts, 32'd1);
        check("bp_cs_low", cs_low, 32'd72);

        // Reset after the third SCLK rise, then a clean transfer
        clear_mon();
        handshake(8'hFF);
        for (int i = 0; i < 200 && rises < 3; i++) begin
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b1;
        #1 check("midreset_outputs", {27'd0, cs_n, sclk, mosi, busy, tx_ready}, {27'd0, 5'b10001});
        @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
        handshake(8'h81);
        wait_idle();
        check("post_reset_byte", {24'd0, rx_bits[7:0]}, 32'h0000_0081);
        check("post_reset_rises", rises, 32'd8);
        check("post_reset_cs_low", cs_low, 32'd72);

`ifdef SPI_TX_MISO_EN
        // Loopback at CLK_DIV = 1
        tx_data1  = 8'h5A;
        tx_valid1 = 1'b1;
        @(posedge clk);
        #1 tx_valid1 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
        end
        check("loop_pulses", rx_pulses1, 32'd1);
        check("loop_rx_data", {24'd0, rx_data1}, 32'h0000_005A);
        check("loop_rx_data_main", {24'd0, rx_data}, 32'h0000_0081);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
